handshake_seq_gen: RTL

//   Stimulus-side producer for the req/ack and enabled-counter assertion checks.
//   - Generates a WIDTH-bit count that advances by +1 on every enabled cycle.
//   - Runs a four-phase req/ack initiator, triggered by each rising edge of en,

---
 rtl/handshake_seq_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/handshake_seq_gen.sv
// handshake_seq_gen: enabled WIDTH-bit up-counter plus a four-phase req/ack
// initiator launched on each rising edge of en, with an ack timeout and a
// saturating count of completed transfers.
module handshake_seq_gen #(
    parameter int WIDTH    = 4,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ack,
    output logic             req,
    output logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] xfer_cnt
);

    // wait_cnt only has to reach MAX_WAIT-1; keep at least one bit
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0]    WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] XFER_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            en_q;
    logic            rise;
    logic [WW-1:0]   wait_cnt;
    logic            xfer_done;
    logic            to_hit;

    assign rise = en & ~en_q;
    assign busy = (state != IDLE);

    // running count: +1 on every enabled edge, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            a    <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= en;
            if (en)
                a <= a + 1'b1;
        end
    end

    // next-state decode; ack takes priority over the timeout check
    always_comb begin
        state_nxt = state;
        xfer_done = 1'b0;
        to_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise)
                    state_nxt = REQ;
            end
            REQ: begin
                if (ack) begin
                    state_nxt = DROP;
                    xfer_done = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = IDLE;
                    to_hit    = 1'b1;
                end
            end
            DROP: begin
                if (!ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, registered req/timeout, wait counter and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            state   <= state_nxt;
            req     <= (state_nxt == REQ);
            timeout <= to_hit;
            if (state == REQ)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (xfer_done && xfer_cnt != XFER_MAX)
                xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule
